pim_dma_sched: RTL and testbench
================================

// Module: pim_dma_sched
// PURPOSE
//  Command queue and sequencer in front of the PIM DMA engine. Accepts PIM transfer commands
//  from the core (write weight/activation/key/vref, load result), buffers them in a FIFO and
//  issues them one at a time to the DMA. Each issue is a single-cycle enable pulse; the next
//  command is held back until the DMA busy flag has risen and fallen. Illegal commands are
//  rejected and the core receives completion/error status.
// PARAMETERS
//  CMD_DEPTH  4   FIFO entries; power of two, >=2
//  BUSY_TMO   16  cycles allowed from the issue pulse to i_dma_busy=1 before a timeout error
// PORTS
//  i_clk            in   1   clock
//  i_rst_n          in   1   async active-low reset
//  i_cmd_valid      in   1   core presents command
//  o_cmd_ready      out  1   queue can accept (=!full)
//  i_cmd_funct3     in   3   001 wr-weight, 010 wr-act, 100 load, 101 key, 110 vref
//  i_cmd_sel_pim    in   4   PIM macro select
//  i_cmd_size       in   13  word count, 1..8191
//  i_cmd_mem_addr   in   32  SRAM word address (bits[1:0] must be 0)
//  i_flush          in   1   drop all queued, unissued commands
//  i_err_clr        in   1   clear sticky error flags
//  o_dma_en         out  1   one-cycle issue pulse to DMA
//  o_dma_funct3     out  3   head command funct3, valid when o_dma_en=1, else 0
//  o_dma_sel_pim    out  4   as above
//  o_dma_size       out  13  as above
//  o_dma_mem_addr   out  32  as above
//  i_dma_busy       in   1   DMA busy status
//  o_queue_count    out  $clog2(CMD_DEPTH)+1  occupied entries
//  o_sched_busy     out  1   state!=IDLE or queue non-empty
//  o_done           out  1   one-cycle pulse when a command completes
//  o_err_illegal    out  1   sticky: rejected command
//  o_err_tmo        out  1   sticky: busy-rise timeout
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, every output 0 except o_cmd_ready=1.
//  Push: i_cmd_valid&&o_cmd_ready. Legal = funct3 in {001,010,100,101,110}, size!=0 and
//   mem_addr[1:0]==0. Legal commands are written to the tail. Illegal commands are consumed
//   (handshake completes) but not queued, and set o_err_illegal.
//  o_cmd_ready depends only on full. No bypass, so a push when full is not accepted, even if a
//   pop occurs in the same cycle.
//  FSM:
//   IDLE: if count!=0 -> ISSUE.
//   ISSUE: o_dma_en=1 with head fields, for exactly 1 cycle; load tmo counter; -> WAIT_BUSY.
//   WAIT_BUSY: i_dma_busy=1 -> WAIT_DONE. Tmo counter reaches BUSY_TMO -> pop head, set
//    o_err_tmo, -> IDLE (no o_done).
//   WAIT_DONE: i_dma_busy=0 -> pop head, o_done=1 that cycle, -> IDLE.
//  Latency: push at cycle t gives o_dma_en at t+2 when the block was idle. Back-to-back
//   commands have >=1 IDLE cycle between busy falling and the next o_dma_en.
//  The head entry stays in the FIFO until it completes; the entry is popped only in WAIT_DONE
//   or on timeout.
//  i_flush:
//   - In IDLE: empties the FIFO.
//   - In ISSUE/WAIT_*: drops all entries except the head; the in-flight command completes
//     normally.
//   - A same-cycle push is discarded.
//  Flags: i_err_clr clears both sticky flags. A same-cycle set wins over the clear.
//  count = pushes - pops. Pointers wrap modulo CMD_DEPTH; full = count==CMD_DEPTH.
//  Async reset mid-transfer returns to the reset state immediately. The DMA is reset by the
//   same reset.
// TESTING
//  1 single cmd (010,sel 3,size 4,addr 0x100), busy high 6 cyc -> en at t+2 with exact fields,
//    1 pulse; o_done 1 cyc after busy falls; count 1->0.
//  2 push 5 legal cmds with DEPTH=4, busy held high -> ready=0 after 4th; 5th accepted only
//    after the first done; issue order FIFO.
//  3 funct3=011, size=0, addr=0x102 -> each consumed, count unchanged, o_err_illegal=1;
//    i_err_clr -> 0.
//  4 busy never rises -> o_err_tmo at issue+BUSY_TMO, head popped, no o_done, next cmd issued.
//  5 3 queued, flush during WAIT_DONE -> count=1, in-flight completes, no further o_dma_en.
//  6 reset asserted in WAIT_DONE with 2 queued -> all outputs 0, ready=1, count=0 next edge.

Source files
------------

// File: rtl/pim_dma_sched.sv
// rtl/pim_dma_sched.sv - PIM DMA command queue and single-issue sequencer
module pim_dma_sched #(
    parameter int CMD_DEPTH = 4,
    parameter int BUSY_TMO  = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_cmd_valid,
    output logic                         o_cmd_ready,
    input  logic [2:0]                   i_cmd_funct3,
    input  logic [3:0]                   i_cmd_sel_pim,
    input  logic [12:0]                  i_cmd_size,
    input  logic [31:0]                  i_cmd_mem_addr,
    input  logic                         i_flush,
    input  logic                         i_err_clr,
    output logic                         o_dma_en,
    output logic [2:0]                   o_dma_funct3,
    output logic [3:0]                   o_dma_sel_pim,
    output logic [12:0]                  o_dma_size,
    output logic [31:0]                  o_dma_mem_addr,
    input  logic                         i_dma_busy,
    output logic [$clog2(CMD_DEPTH):0]   o_queue_count,
    output logic                         o_sched_busy,
    output logic                         o_done,
    output logic                         o_err_illegal,
    output logic                         o_err_tmo
);

    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(BUSY_TMO + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0]    q_funct3   [CMD_DEPTH];
    logic [3:0]    q_sel_pim  [CMD_DEPTH];
    logic [12:0]   q_size     [CMD_DEPTH];
    logic [31:0]   q_mem_addr [CMD_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] tmo_cnt;

    logic          full;
    logic          funct_ok;
    logic          cmd_legal;
    logic          push_acc;
    logic          push_q;
    logic          tmo_hit;
    logic          done_hit;
    logic          pop;

    assign full        = (count == CW'(CMD_DEPTH));
    assign o_cmd_ready = !full;
    assign push_acc    = i_cmd_valid && !full;

    // Decode the supported transfer opcodes.
    always_comb begin
        funct_ok = 1'b0;
        case (i_cmd_funct3)
            3'b001, 3'b010, 3'b100, 3'b101, 3'b110: funct_ok = 1'b1;
            default:                                funct_ok = 1'b0;
        endcase
    end

    assign cmd_legal = funct_ok && (i_cmd_size != 13'd0) && (i_cmd_mem_addr[1:0] == 2'b00);
    // A flush in the same cycle swallows the incoming command.
    assign push_q    = push_acc && cmd_legal && !i_flush;
    // Busy arriving on the last allowed cycle still counts as a normal start.
    assign tmo_hit   = (state == ST_WAIT_BUSY) && !i_dma_busy && (tmo_cnt == TW'(BUSY_TMO));
    assign done_hit  = (state == ST_WAIT_DONE) && !i_dma_busy;
    // The head leaves the queue only once its transfer has finished or been abandoned.
    assign pop       = tmo_hit || done_hit;

    // Command storage; contents need no reset because count gates every read.
    always_ff @(posedge i_clk) begin
        if (push_q) begin
            q_funct3[wr_ptr]   <= i_cmd_funct3;
            q_sel_pim[wr_ptr]  <= i_cmd_sel_pim;
            q_size[wr_ptr]     <= i_cmd_size;
            q_mem_addr[wr_ptr] <= i_cmd_mem_addr;
        end
    end

    // Queue pointers and occupancy, including flush that keeps an in-flight head.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            if (state == ST_IDLE) begin
                wr_ptr <= rd_ptr;
                count  <= '0;
            end else begin
                wr_ptr <= rd_ptr + PW'(1);
                rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
                count  <= pop ? CW'(0) : CW'(1);
            end
        end else begin
            if (push_q) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_q) - CW'(pop);
        end
    end

    // Cycles elapsed since the issue pulse, used to detect a DMA that never starts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            tmo_cnt <= TW'(1);
        end else if ((state == ST_WAIT_BUSY) && (tmo_cnt != TW'(BUSY_TMO))) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_illegal <= 1'b0;
            o_err_tmo     <= 1'b0;
        end else begin
            if (push_acc && !cmd_legal) begin
                o_err_illegal <= 1'b1;
            end else if (i_err_clr) begin
                o_err_illegal <= 1'b0;
            end
            if (tmo_hit) begin
                o_err_tmo <= 1'b1;
            end else if (i_err_clr) begin
                o_err_tmo <= 1'b0;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencer next state plus the issue and completion pulses.
    always_comb begin
        state_nxt = state;
        o_dma_en  = 1'b0;
        o_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((count != '0) && !i_flush) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_dma_en  = 1'b1;
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (i_dma_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (done_hit) begin
                    o_done    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_dma_funct3   = o_dma_en ? q_funct3[rd_ptr]   : 3'd0;
    assign o_dma_sel_pim  = o_dma_en ? q_sel_pim[rd_ptr]  : 4'd0;
    assign o_dma_size     = o_dma_en ? q_size[rd_ptr]     : 13'd0;
    assign o_dma_mem_addr = o_dma_en ? q_mem_addr[rd_ptr] : 32'd0;
    assign o_queue_count  = count;
    assign o_sched_busy   = (state != ST_IDLE) || (count != '0);

endmodule

// File: tb/tb_pim_dma_sched.sv
// tb/tb_pim_dma_sched.sv - scoreboard bench for pim_dma_sched
module tb_pim_dma_sched;

    localparam int CMD_DEPTH = 4;
    localparam int BUSY_TMO  = 16;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [2:0]  i_cmd_funct3;
    logic [3:0]  i_cmd_sel_pim;
    logic [12:0] i_cmd_size;
    logic [31:0] i_cmd_mem_addr;
    logic        i_flush;
    logic        i_err_clr;
    logic        o_dma_en;
    logic [2:0]  o_dma_funct3;
    logic [3:0]  o_dma_sel_pim;
    logic [12:0] o_dma_size;
    logic [31:0] o_dma_mem_addr;
    logic        i_dma_busy;
    logic [2:0]  o_queue_count;
    logic        o_sched_busy;
    logic        o_done;
    logic        o_err_illegal;
    logic        o_err_tmo;

    typedef struct packed {
        logic [2:0]  f3;
        logic [3:0]  sel;
        logic [12:0] size;
        logic [31:0] addr;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t mon_e;
    int   en_hist[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   en_cnt   = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   dma_mode = 0;
    int   busy_len = 6;
    bit   dma_release = 1'b0;

    pim_dma_sched #(.CMD_DEPTH(CMD_DEPTH), .BUSY_TMO(BUSY_TMO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_funct3(i_cmd_funct3), .i_cmd_sel_pim(i_cmd_sel_pim),
        .i_cmd_size(i_cmd_size), .i_cmd_mem_addr(i_cmd_mem_addr),
        .i_flush(i_flush), .i_err_clr(i_err_clr),
        .o_dma_en(o_dma_en), .o_dma_funct3(o_dma_funct3), .o_dma_sel_pim(o_dma_sel_pim),
        .o_dma_size(o_dma_size), .o_dma_mem_addr(o_dma_mem_addr),
        .i_dma_busy(i_dma_busy), .o_queue_count(o_queue_count),
        .o_sched_busy(o_sched_busy), .o_done(o_done),
        .o_err_illegal(o_err_illegal), .o_err_tmo(o_err_tmo)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_legal(input logic [2:0] f3, input logic [12:0] sz, input logic [31:0] a);
        return (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101 || f3 == 3'b110)
               && (sz != 13'd0) && (a[1:0] == 2'b00);
    endfunction

    // Issue monitor: every pulse must match the oldest unissued expected command.
    always @(negedge i_clk) begin
        if (o_dma_en) begin
            en_cnt++;
            en_hist.push_back(cyc);
            if (exp_q.size() == 0) begin
                check_eq("issue_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("issue_cmd", 64'({o_dma_funct3, o_dma_sel_pim, o_dma_size, o_dma_mem_addr}),
                         64'(mon_e));
            end
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // DMA model: mode 0 busy for busy_len cycles, 1 never busy, 2 busy until released.
    initial begin
        i_dma_busy = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_dma_en && dma_mode != 1) begin
                @(posedge i_clk); #1;
                i_dma_busy = 1'b1;
                if (dma_mode == 0) begin
                    for (int k = 1; k < busy_len; k++) @(posedge i_clk);
                end else begin
                    while (!dma_release && i_rst_n) @(posedge i_clk);
                end
                @(posedge i_clk); #1;
                i_dma_busy = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk); #1;
    endtask

    task automatic push_cmd(input logic [2:0] f3, input logic [3:0] sel, input logic [12:0] sz,
                            input logic [31:0] addr, input int max_wait,
                            output bit accepted, output int acc_cyc);
        cmd_t c;
        c = '{f3: f3, sel: sel, size: sz, addr: addr};
        i_cmd_valid = 1'b1; i_cmd_funct3 = f3; i_cmd_sel_pim = sel;
        i_cmd_size = sz; i_cmd_mem_addr = addr;
        accepted = 1'b0;
        acc_cyc  = -1;
        for (int n = 0; n < max_wait && !accepted; n++) begin
            @(negedge i_clk);
            if (o_cmd_ready) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
                if (is_legal(f3, sz, addr) && !i_flush) exp_q.push_back(c);
            end
            step();
        end
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        for (int n = 0; n < budget && done_cnt < target; n++) step();
        check_eq(tag, 64'(done_cnt), 64'(target));
    endtask

    task automatic wait_busy(input string tag, input int budget);
        for (int n = 0; n < budget && !i_dma_busy; n++) step();
        check_eq(tag, 64'(i_dma_busy), 64'd1);
    endtask

    task automatic pulse_err_clr();
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 64'(o_cmd_ready), 64'd1);
        check_eq({tag, "_count"}, 64'(o_queue_count), 64'd0);
        check_eq({tag, "_en"}, 64'(o_dma_en), 64'd0);
        check_eq({tag, "_fields"}, 64'({o_dma_funct3, o_dma_sel_pim, o_dma_size, o_dma_mem_addr}), 64'd0);
        check_eq({tag, "_sbusy"}, 64'(o_sched_busy), 64'd0);
        check_eq({tag, "_done"}, 64'(o_done), 64'd0);
        check_eq({tag, "_eill"}, 64'(o_err_illegal), 64'd0);
        check_eq({tag, "_etmo"}, 64'(o_err_tmo), 64'd0);
    endtask

    logic [2:0]  t2_f3  [4] = '{3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  t3_f3  [3] = '{3'b011, 3'b010, 3'b010};
    logic [12:0] t3_sz  [3] = '{13'd4, 13'd0, 13'd4};
    logic [31:0] t3_ad  [3] = '{32'h200, 32'h200, 32'h102};

    initial begin
        bit acc;
        int t_acc, t5, e0, d0, ea, tmo_cyc, gap;

        i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_funct3 = '0; i_cmd_sel_pim = '0;
        i_cmd_size = '0; i_cmd_mem_addr = '0; i_flush = 1'b0; i_err_clr = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_reset_outputs("rst");
        step();
        i_rst_n = 1'b1;
        step();

        // single command, issue latency, fields and completion
        dma_mode = 0; busy_len = 6; e0 = en_cnt; d0 = done_cnt;
        push_cmd(3'b010, 4'd3, 13'd4, 32'h100, 1, acc, t_acc);
        check_eq("t1_acc", 64'(acc), 64'd1);
        @(negedge i_clk);
        check_eq("t1_count1", 64'(o_queue_count), 64'd1);
        step();
        wait_done("t1_done", d0 + 1, 40);
        check_eq("t1_en_pulses", 64'(en_cnt - e0), 64'd1);
        check_eq("t1_en_lat", 64'(en_hist[en_hist.size()-1] - t_acc), 64'd2);
        check_eq("t1_done_lat", 64'(done_cyc - en_hist[en_hist.size()-1]), 64'd7);
        @(negedge i_clk);
        check_eq("t1_count0", 64'(o_queue_count), 64'd0);
        check_eq("t1_sbusy", 64'(o_sched_busy), 64'd0);
        step();

        // fill to full, blocked fifth push, FIFO issue order
        dma_mode = 2; e0 = en_cnt; d0 = done_cnt;
        for (int k = 0; k < 4; k++) begin
            push_cmd(t2_f3[k], 4'(k + 1), 13'(10 + k), 32'h1000 + 32'(16 * k), 1, acc, t_acc);
            check_eq("t2_acc", 64'(acc), 64'd1);
        end
        @(negedge i_clk);
        check_eq("t2_count_full", 64'(o_queue_count), 64'd4);
        check_eq("t2_ready_full", 64'(o_cmd_ready), 64'd0);
        step();
        fork
            push_cmd(3'b110, 4'd9, 13'd100, 32'h2000, 40, acc, t5);
            begin
                repeat (4) step();
                dma_mode = 0;
                dma_release = 1'b1;
            end
        join
        check_eq("t2_acc5", 64'(acc), 64'd1);
        check_eq("t2_done_before5", 64'(done_cnt - d0), 64'd1);
        check_eq("t2_acc5_cyc", 64'(t5 - done_cyc), 64'd1);
        wait_done("t2_all_done", d0 + 5, 200);
        dma_release = 1'b0;
        check_eq("t2_en_pulses", 64'(en_cnt - e0), 64'd5);
        check_eq("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // illegal commands are consumed, flagged and cleared
        dma_mode = 0; e0 = en_cnt;
        for (int k = 0; k < 3; k++) begin
            push_cmd(t3_f3[k], 4'd1, t3_sz[k], t3_ad[k], 1, acc, t_acc);
            check_eq("t3_acc", 64'(acc), 64'd1);
            @(negedge i_clk);
            check_eq("t3_count", 64'(o_queue_count), 64'd0);
            check_eq("t3_eill_set", 64'(o_err_illegal), 64'd1);
            step();
            pulse_err_clr();
            @(negedge i_clk);
            check_eq("t3_eill_clr", 64'(o_err_illegal), 64'd0);
            step();
        end
        i_err_clr = 1'b1;
        push_cmd(3'b111, 4'd1, 13'd4, 32'h0, 1, acc, t_acc);
        i_err_clr = 1'b0;
        @(negedge i_clk);
        check_eq("t3_set_wins", 64'(o_err_illegal), 64'd1);
        step();
        pulse_err_clr();
        repeat (4) step();
        check_eq("t3_no_issue", 64'(en_cnt - e0), 64'd0);

        // busy never rises: timeout, head dropped, next command still issued
        dma_mode = 1; e0 = en_cnt; d0 = done_cnt; ea = en_hist.size();
        push_cmd(3'b101, 4'd2, 13'd8, 32'h40, 1, acc, t_acc);
        push_cmd(3'b100, 4'd5, 13'd16, 32'h80, 1, acc, t_acc);
        @(negedge i_clk);
        check_eq("t4_count2", 64'(o_queue_count), 64'd2);
        check_eq("t4_etmo_pre", 64'(o_err_tmo), 64'd0);
        tmo_cyc = -1;
        for (int n = 0; n < 60 && tmo_cyc < 0; n++) begin
            step();
            @(negedge i_clk);
            if (o_err_tmo) tmo_cyc = cyc;
        end
        check_eq("t4_tmo_seen", 64'(tmo_cyc >= 0), 64'd1);
        gap = tmo_cyc - en_hist[ea];
        check_eq("t4_tmo_lat", 64'(gap == BUSY_TMO || gap == BUSY_TMO + 1), 64'd1);
        step();
        for (int n = 0; n < 60 && o_sched_busy; n++) step();
        check_eq("t4_en_pulses", 64'(en_cnt - e0), 64'd2);
        check_eq("t4_next_after_tmo", 64'(en_hist[ea+1] - en_hist[ea] > BUSY_TMO), 64'd1);
        check_eq("t4_no_done", 64'(done_cnt - d0), 64'd0);
        check_eq("t4_count0", 64'(o_queue_count), 64'd0);
        pulse_err_clr();
        @(negedge i_clk);
        check_eq("t4_etmo_clr", 64'(o_err_tmo), 64'd0);
        step();

        // flush during WAIT_DONE keeps only the in-flight head
        dma_mode = 2; e0 = en_cnt; d0 = done_cnt;
        for (int k = 0; k < 3; k++) push_cmd(3'b001, 4'(k), 13'd32, 32'h3000 + 32'(k * 4), 1, acc, t_acc);
        wait_busy("t5_busy", 20);
        repeat (2) step();
        i_flush = 1'b1;
        push_cmd(3'b010, 4'd7, 13'd5, 32'h4000, 1, acc, t_acc);
        i_flush = 1'b0;
        exp_q.delete();
        @(negedge i_clk);
        check_eq("t5_count_flush", 64'(o_queue_count), 64'd1);
        step();
        dma_mode = 0;
        dma_release = 1'b1;
        wait_done("t5_done", d0 + 1, 50);
        dma_release = 1'b0;
        repeat (20) step();
        check_eq("t5_en_pulses", 64'(en_cnt - e0), 64'd1);
        @(negedge i_clk);
        check_eq("t5_count0", 64'(o_queue_count), 64'd0);
        step();

        // asynchronous reset in WAIT_DONE with entries queued
        dma_mode = 2; e0 = en_cnt;
        for (int k = 0; k < 3; k++) push_cmd(3'b110, 4'(k), 13'd2, 32'h5000 + 32'(k * 8), 1, acc, t_acc);
        wait_busy("t6_busy", 20);
        repeat (2) step();
        i_rst_n = 1'b0;
        #2;
        check_reset_outputs("t6");
        exp_q.delete();
        dma_mode = 0;
        repeat (2) step();
        i_rst_n = 1'b1;
        repeat (10) step();
        check_eq("t6_en_pulses", 64'(en_cnt - e0), 64'd1);
        @(negedge i_clk);
        check_eq("t6_count0", 64'(o_queue_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
